// File: rtl/frame_schedule_controller_if.sv
// Command-FIFO read port between the RTIO command FIFO and the frame schedule controller.
// The controller owns the pop strobe; the FIFO supplies status and read data.
interface frame_schedule_controller_if #(
  parameter int FIFO_DEPTH = 9
) ();
  logic                  fifo_empty;
  logic [127:0]          fifo_dout;
  logic [FIFO_DEPTH-1:0] data_num;
  logic                  fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout,
    input  data_num
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout,
    output data_num
  );
endinterface

// File: rtl/frame_schedule_controller.sv
// Timed frame-configuration sequencer: pops timestamped entries, waits for their time,
// then loads the new frame size on the frame boundary so it lands exactly on pixel (0,0).
module frame_schedule_controller #(
  parameter int BIT_WIDTH  = 12,
  parameter int BIT_HEIGHT = 11,
  parameter int FIFO_DEPTH = 9
) (
  input  logic                       rtio_clk,
  input  logic                       rtio_reset,
  input  logic                       auto_start,
  input  logic [63:0]                counter,
  frame_schedule_controller_if.master fifo,
  input  logic [BIT_WIDTH-1:0]       cx,
  input  logic [BIT_HEIGHT-1:0]      cy,
  input  logic [BIT_WIDTH-1:0]       screen_width,
  input  logic [BIT_HEIGHT-1:0]      screen_height,
  output logic [BIT_WIDTH-1:0]       frame_width,
  output logic [BIT_HEIGHT-1:0]      frame_height,
  output logic                       frame_update,
  output logic                       late_error,
  output logic                       busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_TIME,
    WAIT_FRAME,
    APPLY
  } state_t;

  state_t state;
  state_t state_next;

  logic [63:0]           ts_q;
  logic                  imm_q;
  logic [BIT_WIDTH-1:0]  width_q;
  logic [BIT_HEIGHT-1:0] height_q;

  logic [63:0]           entry_ts;
  logic                  entry_imm;
  logic [BIT_WIDTH-1:0]  entry_width;
  logic [BIT_HEIGHT-1:0] entry_height;
  logic [BIT_WIDTH-1:0]  clamp_width;
  logic [BIT_HEIGHT-1:0] clamp_height;

  logic boundary;
  logic time_ok;

  // data_num is occupancy for software visibility only; the spare entry bits carry nothing.
  logic [FIFO_DEPTH-1:0] unused_data_num;
  logic                  unused_bits;
  assign unused_data_num = fifo.data_num;
  assign unused_bits     = ^{unused_data_num, fifo.fifo_dout};

  assign entry_ts     = fifo.fifo_dout[63:0];
  assign entry_width  = fifo.fifo_dout[64 +: BIT_WIDTH];
  assign entry_height = fifo.fifo_dout[96 +: BIT_HEIGHT];
  assign entry_imm    = fifo.fifo_dout[127];

  // A zero or oversized request falls back to the full screen dimension.
  assign clamp_width  = (entry_width == '0 || entry_width > screen_width)
                        ? screen_width : entry_width;
  assign clamp_height = (entry_height == '0 || entry_height > screen_height)
                        ? screen_height : entry_height;

  assign boundary = (cx == screen_width  - BIT_WIDTH'(1)) &&
                    (cy == screen_height - BIT_HEIGHT'(1));
  assign time_ok  = imm_q || (counter >= ts_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rtio_clk) begin
    if (rtio_reset) state <= IDLE;
    else            state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves a latch behind.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (auto_start && !fifo.fifo_empty) state_next = FETCH;
      FETCH:      state_next = WAIT_TIME;
      WAIT_TIME:  if (time_ok) state_next = boundary ? APPLY : WAIT_FRAME;
      WAIT_FRAME: if (boundary) state_next = APPLY;
      APPLY:      state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo.fifo_rd_en = 1'b0;
    frame_update    = 1'b0;
    busy            = 1'b1;
    case (state)
      IDLE: begin
        busy            = 1'b0;
        fifo.fifo_rd_en = auto_start && !fifo.fifo_empty && !rtio_reset;
      end
      APPLY:   frame_update = 1'b1;
      default: ;
    endcase
  end

  // Active size loads on the boundary edge itself, so it is already valid during APPLY,
  // which coincides with pixel (0,0).
  always_ff @(posedge rtio_clk) begin
    if (rtio_reset) begin
      ts_q         <= '0;
      imm_q        <= 1'b0;
      width_q      <= '0;
      height_q     <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      late_error   <= 1'b0;
    end else begin
      if (state == FETCH) begin
        ts_q     <= entry_ts;
        imm_q    <= entry_imm;
        width_q  <= clamp_width;
        height_q <= clamp_height;
        if (!entry_imm && counter > entry_ts) late_error <= 1'b1;
      end
      if (state_next == APPLY) begin
        frame_width  <= width_q;
        frame_height <= height_q;
      end
    end
  end

endmodule

// File: tb/tb_frame_schedule_controller.sv
// Bench for frame_schedule_controller: cycle table for the directed scenarios, hand-written
// reset/auto_start sequences, and a randomized run against an arithmetic schedule model.
module tb_frame_schedule_controller;

  logic        rtio_clk = 1'b0;
  logic        rtio_reset;
  logic        auto_start;
  logic [63:0] counter;
  logic [11:0] cx;
  logic [10:0] cy;
  logic [11:0] screen_width;
  logic [10:0] screen_height;
  logic [11:0] frame_width;
  logic [10:0] frame_height;
  logic        frame_update;
  logic        late_error;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  frame_schedule_controller_if #(.FIFO_DEPTH(9)) bus ();

  frame_schedule_controller #(
    .BIT_WIDTH(12), .BIT_HEIGHT(11), .FIFO_DEPTH(9)
  ) dut (
    .rtio_clk      (rtio_clk),
    .rtio_reset    (rtio_reset),
    .auto_start    (auto_start),
    .counter       (counter),
    .fifo          (bus),
    .cx            (cx),
    .cy            (cy),
    .screen_width  (screen_width),
    .screen_height (screen_height),
    .frame_width   (frame_width),
    .frame_height  (frame_height),
    .frame_update  (frame_update),
    .late_error    (late_error),
    .busy          (busy)
  );

  always #5 rtio_clk = ~rtio_clk;

  typedef struct {
    logic         rst;
    logic         as;
    logic [63:0]  ctr;
    logic         emp;
    logic [127:0] dout;
    logic [11:0]  x;
    logic [10:0]  y;
    logic [26:0]  exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] OFF = 64'h0000_0123_0000_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic as, input logic [63:0] ctr,
                       input logic emp, input logic [127:0] dout,
                       input logic [11:0] x, input logic [10:0] y);
    @(negedge rtio_clk);
    rtio_reset     = rst;
    auto_start     = as;
    counter        = ctr;
    bus.fifo_empty = emp;
    bus.fifo_dout  = dout;
    bus.data_num   = emp ? 9'd0 : 9'd1;
    cx             = x;
    cy             = y;
    #1;
  endtask

  function automatic logic [26:0] outs();
    return {bus.fifo_rd_en, frame_update, late_error, busy, frame_width, frame_height};
  endfunction

  function automatic logic [26:0] o(input bit rd, input bit upd, input bit late,
                                    input bit bsy, input int w, input int h);
    return {rd, upd, late, bsy, 12'(w), 11'(h)};
  endfunction

  function automatic logic [127:0] entry(input bit imm, input int w, input int h,
                                         input logic [63:0] ts);
    logic [127:0] e;
    e          = '0;
    e[63:0]    = ts;
    e[75:64]   = 12'(w);
    e[106:96]  = 11'(h);
    e[127]     = imm;
    return e;
  endfunction

  function automatic vec_t row(input logic rst, input logic as, input int ctr, input logic emp,
                               input logic [127:0] dout, input int x, input int y,
                               input logic [26:0] exp);
    vec_t v;
    v.rst = rst; v.as = as; v.ctr = 64'(ctr); v.emp = emp; v.dout = dout;
    v.x = 12'(x); v.y = 11'(y); v.exp = exp;
    return v;
  endfunction

  // Random-run storage
  localparam int K  = 16;
  localparam int SW = 6;
  localparam int SH = 3;
  localparam int N  = SW * SH;
  int           arr [K];
  int           rel [K];
  int           p   [K];
  int           a   [K];
  bit           late_k [K];
  int           wc  [K];
  int           hc  [K];
  logic [127:0] ent [K];

  initial begin
    logic [127:0] e1, e2, e3, e4, e5, e6, e7;
    logic [127:0] dout_next;
    int f, tok, b, t0, w, h, head, last_t;
    bit rd, upd, late, bsy;
    int ew, eh;

    screen_width  = 12'd800;
    screen_height = 11'd600;
    e1 = entry(1'b0, 640, 480, 64'd100);
    e2 = entry(1'b1, 0,   700, 64'd99999);
    e3 = entry(1'b0, 320, 240, 64'd200);
    e4 = entry(1'b0, 100, 90,  64'd50);
    e5 = entry(1'b0, 200, 150, 64'd60);
    e6 = entry(1'b0, 400, 300, 64'd310);
    e7 = entry(1'b1, 50,  40,  64'd0);

    // reset / idle, nonempty FIFO without auto_start, auto_start with empty FIFO
    tbl.push_back(row(1, 0, 0,   1, 0,  10,  10,  o(0,0,0,0,0,0)));
    tbl.push_back(row(0, 0, 0,   0, 0,  10,  10,  o(0,0,0,0,0,0)));
    tbl.push_back(row(0, 1, 0,   1, 0,  10,  10,  o(0,0,0,0,0,0)));
    tbl.push_back(row(0, 0, 0,   1, 0,  10,  10,  o(0,0,0,0,0,0)));
    // ts=100 640x480: boundary before the stamp is ignored, applied after the next one
    tbl.push_back(row(0, 1, 50,  0, 0,  10,  10,  o(1,0,0,0,0,0)));
    tbl.push_back(row(0, 1, 51,  1, e1, 10,  10,  o(0,0,0,1,0,0)));
    tbl.push_back(row(0, 1, 99,  1, 0,  799, 599, o(0,0,0,1,0,0)));
    tbl.push_back(row(0, 1, 100, 1, 0,  10,  10,  o(0,0,0,1,0,0)));
    tbl.push_back(row(0, 1, 150, 1, 0,  500, 300, o(0,0,0,1,0,0)));
    tbl.push_back(row(0, 1, 151, 1, 0,  799, 599, o(0,0,0,1,0,0)));
    tbl.push_back(row(0, 0, 152, 1, 0,  0,   0,   o(0,1,0,1,640,480)));
    tbl.push_back(row(0, 0, 153, 1, 0,  1,   0,   o(0,0,0,0,640,480)));
    // immediate, w=0 h=700 -> clamped to 800x600
    tbl.push_back(row(0, 1, 154, 0, 0,  2,   0,   o(1,0,0,0,640,480)));
    tbl.push_back(row(0, 1, 160, 1, e2, 3,   0,   o(0,0,0,1,640,480)));
    tbl.push_back(row(0, 1, 161, 1, 0,  10,  10,  o(0,0,0,1,640,480)));
    tbl.push_back(row(0, 1, 162, 1, 0,  799, 599, o(0,0,0,1,640,480)));
    tbl.push_back(row(0, 0, 163, 1, 0,  0,   0,   o(0,1,0,1,800,600)));
    tbl.push_back(row(0, 0, 164, 1, 0,  1,   0,   o(0,0,0,0,800,600)));
    // time_ok and boundary in the same cycle
    tbl.push_back(row(0, 1, 170, 0, 0,  10,  10,  o(1,0,0,0,800,600)));
    tbl.push_back(row(0, 1, 171, 1, e3, 10,  10,  o(0,0,0,1,800,600)));
    tbl.push_back(row(0, 1, 180, 1, 0,  799, 599, o(0,0,0,1,800,600)));
    tbl.push_back(row(0, 1, 200, 1, 0,  799, 599, o(0,0,0,1,800,600)));
    tbl.push_back(row(0, 0, 201, 1, 0,  0,   0,   o(0,1,0,1,320,240)));
    tbl.push_back(row(0, 0, 202, 1, 0,  1,   0,   o(0,0,0,0,320,240)));
    // late entry ts=50 at counter 200, then ts=60 back-to-back on the following frame
    tbl.push_back(row(0, 1, 200, 0, 0,  10,  10,  o(1,0,0,0,320,240)));
    tbl.push_back(row(0, 1, 201, 0, e4, 10,  10,  o(0,0,0,1,320,240)));
    tbl.push_back(row(0, 1, 202, 0, 0,  10,  10,  o(0,0,1,1,320,240)));
    tbl.push_back(row(0, 1, 203, 0, 0,  799, 599, o(0,0,1,1,320,240)));
    tbl.push_back(row(0, 1, 204, 0, 0,  0,   0,   o(0,1,1,1,100,90)));
    tbl.push_back(row(0, 1, 205, 0, 0,  1,   0,   o(1,0,1,0,100,90)));
    tbl.push_back(row(0, 1, 206, 1, e5, 2,   0,   o(0,0,1,1,100,90)));
    tbl.push_back(row(0, 1, 207, 1, 0,  10,  10,  o(0,0,1,1,100,90)));
    tbl.push_back(row(0, 1, 208, 1, 0,  500, 300, o(0,0,1,1,100,90)));
    tbl.push_back(row(0, 1, 209, 1, 0,  799, 599, o(0,0,1,1,100,90)));
    tbl.push_back(row(0, 1, 210, 1, 0,  0,   0,   o(0,1,1,1,200,150)));
    tbl.push_back(row(0, 1, 211, 1, 0,  1,   0,   o(0,0,1,0,200,150)));

    drive(1, 0, 0, 1, 0, 12'd10, 11'd10);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].as, tbl[i].ctr, tbl[i].emp, tbl[i].dout, tbl[i].x, tbl[i].y);
      check($sformatf("tbl%0d", i), 64'(outs()), 64'(tbl[i].exp));
    end

    // reset while waiting for the frame: entry dropped, no update at the next boundary
    drive(0, 1, 300, 0, 0,  12'd10,  11'd10);  check("rst6_pop",   64'(bus.fifo_rd_en), 64'd1);
    drive(0, 1, 301, 1, e6, 12'd10,  11'd10);
    drive(0, 1, 320, 1, 0,  12'd10,  11'd10);
    drive(0, 1, 321, 1, 0,  12'd20,  11'd10);  check("rst6_busy",  64'(busy), 64'd1);
    drive(1, 1, 322, 1, 0,  12'd30,  11'd10);  check("rst6_rd",    64'(bus.fifo_rd_en), 64'd0);
    drive(0, 0, 323, 1, 0,  12'd40,  11'd10);
    check("rst6_idle", 64'({busy, late_error, frame_width, frame_height}), 64'd0);
    drive(0, 0, 324, 1, 0,  12'd799, 11'd599);
    drive(0, 0, 325, 1, 0,  12'd0,   11'd0);
    check("rst6_noupd", 64'({frame_update, frame_width}), 64'd0);

    // auto_start dropped mid-entry: entry completes, no further pops
    drive(0, 1, 330, 0, 0,  12'd10,  11'd10);  check("as_pop",     64'(bus.fifo_rd_en), 64'd1);
    drive(0, 0, 331, 0, e7, 12'd10,  11'd10);  check("as_fetch",   64'(bus.fifo_rd_en), 64'd0);
    drive(0, 0, 332, 0, 0,  12'd799, 11'd599);
    drive(0, 0, 333, 0, 0,  12'd0,   11'd0);
    check("as_apply", 64'({frame_update, frame_width, frame_height}), 64'({1'b1, 12'd50, 11'd40}));
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 64'(334 + i), 0, 0, 12'(1 + i), 11'd0);
      check($sformatf("as_hold%0d", i), 64'({bus.fifo_rd_en, busy}), 64'd0);
    end

    // randomized run on a 6x3 screen scanned continuously; counter = OFF + cycle
    t0 = 0;
    for (int k = 0; k < K; k++) begin
      t0 += int'($urandom_range(0, 30));
      arr[k] = t0;
      ent[k] = {$urandom, $urandom, $urandom, $urandom};
      ent[k][127] = ($urandom_range(0, 3) == 0);
      rel[k] = arr[k] + int'($urandom_range(0, 60)) - 20;
      ent[k][63:0] = OFF + 64'(longint'(rel[k]));
      w = int'($urandom_range(0, 9));
      h = int'($urandom_range(0, 4));
      ent[k][75:64]  = 12'(w);
      ent[k][106:96] = 11'(h);
      wc[k] = (w == 0 || w > SW) ? SW : w;
      hc[k] = (h == 0 || h > SH) ? SH : h;
    end
    f = 0;
    for (int k = 0; k < K; k++) begin
      p[k] = (arr[k] > f) ? arr[k] : f;
      late_k[k] = !ent[k][127] && (p[k] + 1 > rel[k]);
      tok = p[k] + 2;
      if (!ent[k][127] && rel[k] > tok) tok = rel[k];
      b = tok + (N - 1 - tok % N);
      a[k] = b + 1;
      f = a[k] + 1;
    end
    last_t = a[K-1] + 4;

    screen_width  = 12'(SW);
    screen_height = 11'(SH);
    drive(1, 0, OFF, 1, 0, 12'd0, 11'd0);
    head = 0;
    dout_next = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < last_t; t++) begin
      drive(0, 1, OFF + 64'(t), !(head < K && arr[head] <= t), dout_next,
            12'((t % N) % SW), 11'((t % N) / SW));
      rd = 0; upd = 0; late = 0; bsy = 0; ew = 0; eh = 0;
      for (int k = 0; k < K; k++) begin
        if (p[k] == t) rd = 1;
        if (a[k] == t) upd = 1;
        if (late_k[k] && p[k] + 2 <= t) late = 1;
        if (p[k] + 1 <= t && t <= a[k]) bsy = 1;
        if (a[k] <= t) begin ew = wc[k]; eh = hc[k]; end
      end
      check($sformatf("rand_t%0d", t), 64'(outs()), 64'(o(rd, upd, late, bsy, ew, eh)));
      if (bus.fifo_rd_en === 1'b1 && head < K) begin
        dout_next = ent[head];
        head++;
      end else begin
        dout_next = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
